// File: rtl/cart_rom_fetch.sv
// ROM fetch engine behind the N64 cartridge bus decoder: returns big-endian halfwords
// from a two-word buffer (current + prefetched next) backed by a req/ack memory port.
module cart_rom_fetch #(
    parameter logic [31:0] ROM_BASE  = 32'h1000_0000,
    parameter int unsigned ROM_AW    = 26,
    parameter logic [15:0] IDLE_DATA = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic              addr_ready,
    output logic [15:0]       data,
    output logic              data_valid,
    output logic              mem_req,
    output logic [ROM_AW-3:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       miss_cnt
);
    localparam int unsigned WW = ROM_AW - 2;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDfetch = 2'd1;
    localparam logic [1:0] StPfetch = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ready_q;
    logic [WW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
    logic [31:0]   cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
    logic          cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
    logic [WW-1:0] mem_addr_q, mem_addr_d, redo_tag_q, redo_tag_d;
    logic          mem_req_q, mem_req_d;
    logic          redo_q, redo_d, deliver_q, deliver_d, half_q, half_d;
    logic [15:0]   data_q, data_d, miss_q, miss_d;
    logic          valid_q, valid_d;

    logic          rise, in_win;
    logic [WW-1:0] w, w_inc;
    logic          unused_addr;

    assign rise        = addr_ready & ~ready_q;
    assign in_win      = (addr[31:ROM_AW] == ROM_BASE[31:ROM_AW]);
    assign w           = addr[ROM_AW-1:2];
    assign w_inc       = w + WW'(1);
    assign unused_addr = addr[0];

    function automatic logic [15:0] pick(input logic [31:0] word, input logic sel);
        return sel ? word[15:0] : word[31:16];
    endfunction

    // The ack is folded in first so a rise in the same cycle sees the freshly filled buffers.
    always_comb begin
        state_d    = state_q;
        cur_tag_d  = cur_tag_q;
        cur_word_d = cur_word_q;
        cur_vld_d  = cur_vld_q;
        nxt_tag_d  = nxt_tag_q;
        nxt_word_d = nxt_word_q;
        nxt_vld_d  = nxt_vld_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        redo_d     = redo_q;
        redo_tag_d = redo_tag_q;
        deliver_d  = deliver_q;
        half_d     = half_q;
        data_d     = data_q;
        valid_d    = valid_q;
        miss_d     = miss_q;

        if (mem_ack && state_q != StIdle) begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
            if (redo_q) begin
                // Stale word: drop it and chase the word actually demanded.
                mem_req_d  = 1'b1;
                mem_addr_d = redo_tag_q;
                state_d    = StDfetch;
                redo_d     = 1'b0;
            end else if (state_q == StDfetch) begin
                cur_tag_d  = mem_addr_q;
                cur_word_d = mem_rdata;
                cur_vld_d  = 1'b1;
                if (deliver_q) begin
                    data_d  = pick(mem_rdata, half_q);
                    valid_d = 1'b1;
                end
                deliver_d  = 1'b0;
                mem_req_d  = 1'b1;
                mem_addr_d = mem_addr_q + WW'(1);
                state_d    = StPfetch;
            end else begin
                nxt_tag_d  = mem_addr_q;
                nxt_word_d = mem_rdata;
                nxt_vld_d  = 1'b1;
            end
        end

        if (rise) begin
            if (!in_win) begin
                data_d    = IDLE_DATA;
                valid_d   = 1'b1;
                deliver_d = 1'b0;
            end else if (cur_vld_d && cur_tag_d == w) begin
                data_d    = pick(cur_word_d, addr[1]);
                valid_d   = 1'b1;
                deliver_d = 1'b0;
            end else if (nxt_vld_d && nxt_tag_d == w) begin
                cur_tag_d  = nxt_tag_d;
                cur_word_d = nxt_word_d;
                cur_vld_d  = 1'b1;
                nxt_vld_d  = 1'b0;
                data_d     = pick(nxt_word_d, addr[1]);
                valid_d    = 1'b1;
                deliver_d  = 1'b0;
                if (state_d == StIdle) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = w_inc;
                    state_d    = StPfetch;
                end
            end else begin
                cur_vld_d = 1'b0;
                nxt_vld_d = 1'b0;
                valid_d   = 1'b0;
                deliver_d = 1'b1;
                half_d    = addr[1];
                if (miss_q != 16'hFFFF) begin
                    miss_d = miss_q + 16'd1;
                end
                if (state_d == StIdle) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = w;
                    redo_d     = 1'b0;
                end else begin
                    // A request in flight cannot be withdrawn; reuse it only if it is our word.
                    redo_d     = (mem_addr_d != w);
                    redo_tag_d = w;
                end
                state_d = StDfetch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            cur_tag_q  <= '0;
            cur_word_q <= '0;
            cur_vld_q  <= 1'b0;
            nxt_tag_q  <= '0;
            nxt_word_q <= '0;
            nxt_vld_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            redo_q     <= 1'b0;
            redo_tag_q <= '0;
            deliver_q  <= 1'b0;
            half_q     <= 1'b0;
            data_q     <= IDLE_DATA;
            valid_q    <= 1'b0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= addr_ready;
            cur_tag_q  <= cur_tag_d;
            cur_word_q <= cur_word_d;
            cur_vld_q  <= cur_vld_d;
            nxt_tag_q  <= nxt_tag_d;
            nxt_word_q <= nxt_word_d;
            nxt_vld_q  <= nxt_vld_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            redo_q     <= redo_d;
            redo_tag_q <= redo_tag_d;
            deliver_q  <= deliver_d;
            half_q     <= half_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            miss_q     <= miss_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Bench for cart_rom_fetch: directed plan steps, then random accesses checked against a
// word-level model of the buffered pair {last word, last word + 1}.
module tb_cart_rom_fetch;
    localparam logic [15:0] IDLE = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        addr_ready = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] data, miss_cnt;
    logic        data_valid, mem_req;
    logic [23:0] mem_addr;
    logic        r_ack = 1'b0, man_ack = 1'b0;
    logic [31:0] r_rdata = '0;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    assign mem_ack   = r_ack | man_ack;
    assign mem_rdata = man_ack ? 32'hDEAD_BEEF : r_rdata;

    cart_rom_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .addr_ready (addr_ready),
        .data       (data),
        .data_valid (data_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .miss_cnt   (miss_cnt)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [23:0] w);
        if (w == 24'd0) return 32'hAABB_CCDD;
        return ({8'h00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: captures each request, acks after ack_delay cycles.
    bit          resp_en = 1'b1;
    int          ack_delay = 0;
    bit          busy = 1'b0;
    int          lat = 0;
    logic [23:0] held = '0;
    logic [23:0] req_log[$];

    always @(negedge clk) begin
        r_ack = 1'b0;
        if (resp_en) begin
            if (!busy && mem_req) begin
                busy = 1'b1;
                held = mem_addr;
                lat  = ack_delay;
                req_log.push_back(mem_addr);
            end else if (busy) begin
                chk("req_held", mem_req, 1);
                chk("addr_stable", mem_addr, held);
            end
            if (busy) begin
                if (lat == 0) begin
                    r_ack   = 1'b1;
                    r_rdata = rom_word(held);
                    busy    = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Model: after each settled access the buffer pair is {mc, mc+1}.
    bit          have = 1'b0;
    logic [23:0] mc = '0;
    int          exp_miss = 0;

    task automatic rise(input logic [31:0] a);
        @(negedge clk);
        addr       = a;
        addr_ready = 1'b1;
        @(negedge clk);
        addr_ready = 1'b0;
    endtask

    task automatic wait_quiet();
        int k = 0;
        int quiet = 0;
        while (k < 300 && quiet < 2) begin
            @(negedge clk);
            quiet = mem_req ? 0 : quiet + 1;
            k++;
        end
        chk("quiet_timeout", quiet, 2);
    endtask

    task automatic check_reqs(input string tag, input logic [23:0] exp_reqs[$]);
        chk({tag, "_req_count"}, req_log.size(), exp_reqs.size());
        for (int i = 0; i < exp_reqs.size() && i < req_log.size(); i++)
            chk({tag, "_req_addr"}, req_log[i], exp_reqs[i]);
    endtask

    task automatic access(input logic [31:0] a);
        logic [23:0] w, wn, mn;
        logic [31:0] word;
        logic [15:0] exp_d;
        logic [23:0] exp_reqs[$];
        bit          win;
        w     = a[25:2];
        wn    = w + 24'd1;
        mn    = mc + 24'd1;
        word  = rom_word(w);
        exp_d = a[1] ? word[15:0] : word[31:16];
        win   = (a[31:26] == 6'd4);
        req_log.delete();
        rise(a);
        if (!win) begin
            chk("oow_data", data, IDLE);
            chk("oow_valid", data_valid, 1);
            chk("oow_noreq", mem_req, 0);
            exp_d = IDLE;
        end else if (have && w == mc) begin
            chk("cur_hit_data", data, exp_d);
            chk("cur_hit_valid", data_valid, 1);
            chk("cur_hit_noreq", mem_req, 0);
        end else if (have && w == mn) begin
            chk("nxt_hit_data", data, exp_d);
            chk("nxt_hit_valid", data_valid, 1);
            chk("nxt_hit_pf_req", mem_req, 1);
            chk("nxt_hit_pf_addr", mem_addr, wn);
            exp_reqs.push_back(wn);
            mc = w;
        end else begin
            chk("miss_valid_low", data_valid, 0);
            chk("miss_req", mem_req, 1);
            chk("miss_addr", mem_addr, w);
            exp_reqs.push_back(w);
            exp_reqs.push_back(wn);
            if (exp_miss < 65535) exp_miss++;
            mc   = w;
            have = 1'b1;
        end
        wait_quiet();
        chk("final_data", data, exp_d);
        chk("final_valid", data_valid, 1);
        chk("final_miss", miss_cnt, exp_miss);
        check_reqs("acc", exp_reqs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] exp_reqs[$];
        logic [31:0] r, a;
        logic [23:0] wt;
        int          k, kind, off;

        repeat (3) @(negedge clk);
        chk("rst_data", data, IDLE);
        chk("rst_valid", data_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_miss", miss_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First demand fetch and burst through word 0 / word 1.
        access(32'h1000_0000);
        chk("first_data", data, 16'hAABB);
        chk("first_miss", miss_cnt, 1);
        access(32'h1000_0002);
        chk("burst_ccdd", data, 16'hCCDD);
        access(32'h1000_0004);
        access(32'h1000_0006);
        chk("burst_miss", miss_cnt, 1);
        access(32'h0500_0000);
        chk("oow_miss", miss_cnt, 1);

        // Miss while the prefetch of word 1 is pending.
        ack_delay = 5;
        req_log.delete();
        rise(32'h1000_0000);
        chk("s5_miss_valid", data_valid, 0);
        k = 0;
        while (k < 100 && !data_valid) begin
            @(negedge clk);
            k++;
        end
        chk("s5_fill_data", data, 16'hAABB);
        chk("s5_pf_req", mem_req, 1);
        chk("s5_pf_addr", mem_addr, 1);
        rise(32'h1000_0040);
        chk("s5_redo_valid", data_valid, 0);
        chk("s5_held_addr", mem_addr, 1);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!mem_ack && k < 100);
        chk("s5_ack_seen", mem_ack, 1);
        @(negedge clk);
        chk("s5_redo_req", mem_req, 1);
        chk("s5_redo_addr", mem_addr, 16);
        chk("s5_still_invalid", data_valid, 0);
        wait_quiet();
        r = rom_word(24'd16);
        chk("s5_data", data, r[31:16]);
        chk("s5_valid", data_valid, 1);
        exp_miss += 2;
        chk("s5_miss", miss_cnt, exp_miss);
        exp_reqs = '{24'd0, 24'd1, 24'd16, 24'd17};
        check_reqs("s5", exp_reqs);
        have = 1'b1;
        mc   = 24'd16;

        // Last word of the window; the prefetch wraps to word 0.
        ack_delay = 1;
        access(32'h13FF_FFFC);
        access(32'h1000_0002);

        // Reset in the middle of a demand fetch; stray ack afterwards.
        resp_en = 1'b0;
        rise(32'h1000_0100);
        chk("rstmid_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_req_low", mem_req, 0);
        chk("rstmid_valid", data_valid, 0);
        chk("rstmid_miss", miss_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        chk("stray_req", mem_req, 0);
        chk("stray_valid", data_valid, 0);
        chk("stray_data", data, IDLE);
        chk("stray_miss", miss_cnt, 0);
        have     = 1'b0;
        mc       = '0;
        exp_miss = 0;
        resp_en  = 1'b1;

        // Random accesses around the current word, a small region, and outside the window.
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 3);
            kind      = $urandom_range(0, 9);
            r         = $urandom;
            if (kind < 2) begin
                if (r[31:26] == 6'd4) r[31] = 1'b1;
                a = r;
            end else if (kind < 6) begin
                off = $urandom_range(0, 3) - 1;
                wt  = mc + 24'(off);
                a   = {6'd4, wt, r[1], r[0]};
            end else begin
                wt = 24'($urandom_range(0, 15));
                a  = {6'd4, wt, r[1], r[0]};
            end
            access(a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cart_rom_fetch.md
# cart_rom_fetch

Downstream consumer of the N64 cartridge bus decoder (`n64_bus`). It watches the decoded `addr`/`addr_ready` pair and fetches 32-bit words from the backing ROM memory through a req/ack port. It returns the addressed big-endian halfword on `data`, which the decoder drives onto AD. A two-entry word buffer (current word plus prefetched next word) lets the auto-incrementing burst reads (`addr` + 2 per READ pulse) hit without a memory round trip.

## Interface
Parameters
- `ROM_BASE`, 32'h1000_0000: byte base address of the cartridge ROM window.
- `ROM_AW`, 26: byte-address bits inside the window (64 MiB).
- `IDLE_DATA`, 16'h0000: value on `data` for out-of-window addresses and after reset.

Ports
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `addr`  in  32: decoded bus byte address, synchronous to `clk`.
- `addr_ready`  in  1: high while `addr` is valid; each rising edge is a new access.
- `data`  out  16: halfword returned to the bus decoder.
- `data_valid`  out  1: `data` corresponds to the current `addr`.
- `mem_req`  out  1: memory read request.
- `mem_addr`  out  ROM_AW-2: word address in the window.
- `mem_ack`  in  1: single-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: fetched word.
- `miss_cnt`  out  16: saturating count of demand misses.

## Operation
- Access detection: `addr_ready` is registered once. Rise = `addr_ready & ~prev`. Falls are ignored.
- Window check: `addr[31:ROM_AW] == ROM_BASE[31:ROM_AW]`. On a miss of the window: `data` <= IDLE_DATA, `data_valid` <= 1, no fetch, buffers untouched.
- Word tag: `w = addr[ROM_AW-1:2]`. Half select: `addr[1]==0` selects `word[31:16]`; `addr[1]==1` selects `word[15:0]`.
- Buffers: CUR (tag, word, valid) and NXT (tag, word, valid).
- On rise, in priority order:
  - CUR hit: output from CUR.
  - NXT hit: copy NXT into CUR, output, clear NXT, start prefetch of w+1.
  - Otherwise demand miss: clear CUR/NXT, `data_valid` <= 0, `miss_cnt` += 1 (saturates at 16'hFFFF), fetch w into CUR.
- States:
  - IDLE.
  - DFETCH: demand fetch outstanding.
  - PFETCH: prefetch outstanding.
- DFETCH + ack: fill CUR, output the half for the latched `addr[1]`, `data_valid` <= 1, go to PFETCH for w+1.
- PFETCH + ack: fill NXT, go to IDLE.
- Request rule:
  - `mem_req` and `mem_addr` are held stable from assertion until the cycle `mem_ack` is sampled high.
  - `mem_req` deasserts the following cycle unless a new request is issued.
  - Requests are never withdrawn.
- Rise during an outstanding fetch:
  - The hit check runs against valid entries only.
  - If the outstanding fetch's tag equals the new demand word, it becomes/stays DFETCH.
  - Otherwise the returning word is discarded and a new DFETCH for the new word is issued the cycle after the ack.
- Prefetch address is (w+1) mod 2^(ROM_AW-2); it wraps to word 0 at the window top.

## Timing
- Reset values: `data`=IDLE_DATA, `data_valid`=0, `mem_req`=0, `mem_addr`=0, `miss_cnt`=0, CUR/NXT invalid, state IDLE.
- `addr_ready` rise sampled at edge N: the rise is detected at N+1.
  - Hit or out-of-window: `data`/`data_valid` update at N+1.
  - Miss: `data_valid` drops at N+1, `mem_req` rises at N+1.
- Demand fill: ack sampled at edge K gives `data`/`data_valid`=1 at K+1, with prefetch `mem_req` at K+1.
- Back-to-back rises 1 cycle apart are accepted; each is evaluated in order.
- Reset mid-fetch: `mem_req` drops immediately. The memory must complete or drop the transaction; an ack arriving after reset is ignored.

## Test plan
- Reset, then rise at addr 32'h1000_0000 with ROM word 32'hAABB_CCDD -> `mem_req` with `mem_addr`=0; after ack, `data`=16'hAABB, `data_valid`=1, `miss_cnt`=1; prefetch with `mem_addr`=1 follows.
- Burst 32'h1000_0000, _0002, _0004, _0006, each rise after the prefetch completes -> `data` AABB, CCDD, then word-1 halves; `miss_cnt` stays 1; `mem_addr`=2 prefetched.
- Rise at 32'h0500_0000 -> `data`=IDLE_DATA on the next cycle, no `mem_req`, `miss_cnt` unchanged.
- Rise at 32'h1000_0040 while a prefetch of word 1 is pending with ack delayed 5 cycles -> word-1 data discarded, `mem_addr`=16 issued the cycle after the ack, correct data returned, `miss_cnt`+1.
- Rise at 32'h13FF_FFFC (last word) -> demand `mem_addr`=24'hFF_FFFF, then prefetch `mem_addr`=0 (wrap).
- `rst_n` low during DFETCH -> `mem_req`, `data_valid`, and `miss_cnt` go to 0 asynchronously; a stray ack afterwards changes nothing.
